seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg_scan_driver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan driver: refresh prescaler, digit select, frame snapshot, segment decode.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit0 always shown).
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [1:0]  sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        scan_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             scan_tick_q, scan_tick_d;
  logic [15:0]      snapshot_q, snapshot_d;
  logic [3:0]       dp_snap_q, dp_snap_d;
  logic             term_cnt;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Prescaler, digit select and frame snapshot
  always_comb begin
    term_cnt    = (div_cnt_q == CNT_MAX);
    div_cnt_d   = term_cnt ? '0 : div_cnt_q + CNT_W'(1);
    sel_d       = sel_q;
    scan_tick_d = 1'b0;
    snapshot_d  = snapshot_q;
    dp_snap_d   = dp_snap_q;
    if (term_cnt) begin
      sel_d       = sel_q + 2'd1;
      scan_tick_d = 1'b1;
      if (sel_q == 2'd3) begin
        snapshot_d = digits;
        dp_snap_d  = dp_in;
      end
    end
  end

  // Segment/dp outputs follow the new sel value and the (possibly just captured) snapshot
  always_comb begin
    logic [3:0] nib;
    logic       digit_off;
    nib       = snapshot_d[{sel_d, 2'b00} +: 4];
    digit_off = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (sel_d)
      2'd3:    digit_off = (snapshot_d[15:12] == 4'h0);
      2'd2:    digit_off = (snapshot_d[15:8] == 8'h00);
      2'd1:    digit_off = (snapshot_d[15:4] == 12'h000);
      default: digit_off = 1'b0;
    endcase
`endif
    seg_d = seg_q;
    dp_d  = dp_q;
    if (blank) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else if (term_cnt) begin
      seg_d = digit_off ? 7'h7F : decode(nib);
      dp_d  = ~dp_snap_d[sel_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      sel_q       <= 2'd0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      scan_tick_q <= 1'b0;
      snapshot_q  <= 16'h0000;
      dp_snap_q   <= 4'h0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      scan_tick_q <= scan_tick_d;
      snapshot_q  <= snapshot_d;
      dp_snap_q   <= dp_snap_d;
    end
  end

  assign sel       = sel_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (REFRESH_DIV=4): model pushes expected outputs per edge,
// a monitor pops and compares one cycle-worth of sel/seg/dp/scan_tick after each edge.
module tb_seg_scan_driver;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank = 1'b0;
  logic [1:0]  sel;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .blank(blank),
    .sel(sel), .seg(seg), .dp(dp), .scan_tick(scan_tick)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: edges since reset, frame being displayed, held display value
  int          m_k = 0;
  int          m_sel = 0;
  logic [15:0] m_frame = 16'h0000;
  logic [3:0]  m_dpf = 4'h0;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;
  logic        m_tick = 1'b0;

  function automatic logic [6:0] digit_seg(input logic [15:0] f, input int s);
    int n;
    n = int'((f >> (4 * s)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0 && (f >> (4 * s)) == 16'h0) return 7'h7F;
`endif
    return seg_lut[n];
  endfunction

  task automatic step(input logic r, input logic [15:0] d, input logic [3:0] p, input logic b);
    exp_t e;
    reset  = r;
    digits = d;
    dp_in  = p;
    blank  = b;
    if (r) begin
      m_k = 0; m_sel = 0; m_frame = 16'h0; m_dpf = 4'h0;
      m_seg = 7'h7F; m_dp = 1'b1; m_tick = 1'b0;
    end else begin
      m_k++;
      m_tick = ((m_k % DIV) == 0);
      m_sel  = (m_k / DIV) % 4;
      if (m_tick && m_sel == 0) begin
        m_frame = d;
        m_dpf   = p;
      end
      if (b) begin
        m_seg = 7'h7F;
        m_dp  = 1'b1;
      end else if (m_tick) begin
        m_seg = digit_seg(m_frame, m_sel);
        m_dp  = ~m_dpf[m_sel];
      end
    end
    e.sel  = 2'(m_sel);
    e.seg  = m_seg;
    e.dp   = m_dp;
    e.tick = m_tick;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after the edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({sel, seg, dp, scan_tick} !== e) begin
        miscompares++;
        $display("FAIL out_vec t=%0t: got sel=%0d seg=%h dp=%b tick=%b, want sel=%0d seg=%h dp=%b tick=%b",
                 $time, sel, seg, dp, scan_tick, e.sel, e.seg, e.dp, e.tick);
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic [3:0]  rp;
    logic        rb;
    repeat (3) step(1'b1, 16'h0, 4'h0, 1'b0);
    repeat (24) step(1'b0, 16'h0, 4'h0, 1'b0);
    repeat (40) step(1'b0, 16'h4321, 4'h0, 1'b0);
    while (m_sel != 1) step(1'b0, 16'h4321, 4'h0, 1'b0);
    repeat (36) step(1'b0, 16'hABCD, 4'h0, 1'b0);
    repeat (10) step(1'b0, 16'hABCD, 4'h0, 1'b1);
    repeat (20) step(1'b0, 16'hABCD, 4'h0, 1'b0);
    repeat (40) step(1'b0, 16'h0007, 4'b0100, 1'b0);
    while (!(m_sel == 2 && (m_k % DIV) == 1)) step(1'b0, 16'h0007, 4'b0100, 1'b0);
    step(1'b1, 16'h0007, 4'b0100, 1'b0);
    repeat (20) step(1'b0, 16'h0007, 4'b0100, 1'b0);

    rd = 16'($urandom);
    rp = 4'($urandom);
    rb = 1'b0;
    repeat (500) begin
      if ($urandom_range(0, 19) == 0) begin
        rd = 16'($urandom);
        rp = 4'($urandom);
      end
      rb = ($urandom_range(0, 14) == 0) ? ~rb : rb;
      step(($urandom_range(0, 149) == 0), rd, rp, rb);
    end

    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
